// File: rtl/jtag_bridge_pkg.sv
// Shared constants and types for the BSCANE2 USER4 command bridge.
// Capture word layout is {status[2:0], rsp[31:0]}, command word is {op[2:0], payload[31:0]}.
package jtag_bridge_pkg;

    localparam int JDATA_WIDTH  = 35;

    localparam int ST_RSP_FULL  = 34;
    localparam int ST_OVERRUN   = 33;
    localparam int ST_FRAME_ERR = 32;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CAP   = 2'd1,
        S_SHIFT = 2'd2,
        S_UPD   = 2'd3
    } state_e;

    localparam logic [2:0] OP_NOP     = 3'd0;
    localparam logic [2:0] OP_READ    = 3'd1;
    localparam logic [2:0] OP_WRITE   = 3'd2;
    localparam logic [2:0] OP_RSP_ACK = 3'd3;

endpackage

// File: rtl/jtag_sig_sync.sv
// Multi-flop synchronizer for one raw JTAG signal, with a rising-edge strobe
// derived from the synchronized value and its one-cycle-delayed copy.
module jtag_sig_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic d_i,
    output logic sync_o,
    output logic rise_o
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
            prev_q <= sync_q[SYNC_STAGES-1];
        end
    end

    assign sync_o = sync_q[SYNC_STAGES-1];
    assign rise_o = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/jtag_cmd_bridge.sv
// Fabric-side DR for the USER4 chain: oversamples TCK in debug_clock, shifts a
// JDATA_WIDTH-bit register and exchanges command/response words with the fabric.
module jtag_cmd_bridge
    import jtag_bridge_pkg::*;
#(
    parameter int JDATA_WIDTH = jtag_bridge_pkg::JDATA_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                   debug_clock_i,
    input  logic                   debug_reset_n_i,
    input  logic                   jtag_tck_i,
    input  logic                   jtag_tdi_i,
    input  logic                   jtag_sel_i,
    input  logic                   jtag_shift_i,
    input  logic                   jtag_capture_i,
    input  logic                   jtag_update_i,
    output logic                   jtag_tdo_o,
    output logic                   cmd_valid_o,
    input  logic                   cmd_ready_i,
    output logic [JDATA_WIDTH-1:0] cmd_data_o,
    input  logic                   rsp_valid_i,
    output logic                   rsp_ready_o,
    input  logic [JDATA_WIDTH-4:0] rsp_data_i,
    output logic                   overrun_o,
    output logic                   frame_err_o
);

    localparam int             CW       = $clog2(JDATA_WIDTH + 2);
    localparam logic [CW-1:0]  CNT_FULL = CW'(JDATA_WIDTH);
    localparam logic [CW-1:0]  CNT_SAT  = CW'(JDATA_WIDTH + 1);

    logic [5:0] raw, sync_s, rise_s;
    logic       tck_rise, tdi_s, sel_s, shift_s, cap_s, upd_rise;
    logic       unused_sync;

    assign raw = {jtag_update_i, jtag_capture_i, jtag_shift_i,
                  jtag_sel_i, jtag_tdi_i, jtag_tck_i};

    for (genvar g = 0; g < 6; g++) begin : g_sync
        jtag_sig_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
            .clk_i  (debug_clock_i),
            .rst_ni (debug_reset_n_i),
            .d_i    (raw[g]),
            .sync_o (sync_s[g]),
            .rise_o (rise_s[g])
        );
    end

    assign tck_rise    = rise_s[0];
    assign tdi_s       = sync_s[1];
    assign sel_s       = sync_s[2];
    assign shift_s     = sync_s[3];
    assign cap_s       = sync_s[4];
    assign upd_rise    = rise_s[5];
    assign unused_sync = ^{rise_s[4:1], sync_s[0], sync_s[5]};

    state_e                 state_q, state_d;
    logic [JDATA_WIDTH-1:0] dr_q, dr_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic [JDATA_WIDTH-1:0] cmd_data_q, cmd_data_d;
    logic                   cmd_valid_q, cmd_valid_d;
    logic [JDATA_WIDTH-4:0] rsp_buf_q, rsp_buf_d;
    logic                   rsp_full_q, rsp_full_d;
    logic                   overrun_q, overrun_d;
    logic                   frame_err_q, frame_err_d;
    logic                   tdo_q;

    always_ff @(posedge debug_clock_i or negedge debug_reset_n_i) begin
        if (!debug_reset_n_i) begin
            state_q     <= S_IDLE;
            dr_q        <= '0;
            cnt_q       <= '0;
            cmd_data_q  <= '0;
            cmd_valid_q <= 1'b0;
            rsp_buf_q   <= '0;
            rsp_full_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            tdo_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dr_q        <= dr_d;
            cnt_q       <= cnt_d;
            cmd_data_q  <= cmd_data_d;
            cmd_valid_q <= cmd_valid_d;
            rsp_buf_q   <= rsp_buf_d;
            rsp_full_q  <= rsp_full_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            tdo_q       <= dr_q[0];
        end
    end

    always_comb begin
        state_d     = state_q;
        dr_d        = dr_q;
        cnt_d       = cnt_q;
        cmd_data_d  = cmd_data_q;
        cmd_valid_d = cmd_valid_q;
        rsp_buf_d   = rsp_buf_q;
        rsp_full_d  = rsp_full_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        if (cmd_valid_q && cmd_ready_i) begin
            cmd_valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (tck_rise && sel_s && cap_s) state_d = S_CAP;
            end
            S_CAP: begin
                // Status flags are read-to-clear: the host sees them exactly once.
                dr_d        = {rsp_full_q, overrun_q, frame_err_q, rsp_buf_q};
                cnt_d       = '0;
                rsp_full_d  = 1'b0;
                overrun_d   = 1'b0;
                frame_err_d = 1'b0;
                state_d     = S_SHIFT;
            end
            S_SHIFT: begin
                if (tck_rise && shift_s) begin
                    dr_d = {tdi_s, dr_q[JDATA_WIDTH-1:1]};
                    if (cnt_q != CNT_SAT) cnt_d = cnt_q + 1'b1;
                end
                if (!sel_s)        state_d = S_IDLE;
                else if (upd_rise) state_d = S_UPD;
            end
            S_UPD: begin
                if (cnt_q != CNT_FULL) begin
                    frame_err_d = 1'b1;
                end else if (cmd_valid_q && !cmd_ready_i) begin
                    overrun_d = 1'b1;
                end else begin
                    cmd_data_d  = dr_q;
                    cmd_valid_d = 1'b1;
                end
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A push after the capture clear lets a same-cycle response survive.
        if (rsp_valid_i && !rsp_full_q) begin
            rsp_buf_d  = rsp_data_i;
            rsp_full_d = 1'b1;
        end
    end

    assign jtag_tdo_o  = tdo_q;
    assign cmd_valid_o = cmd_valid_q;
    assign cmd_data_o  = cmd_data_q;
    assign rsp_ready_o = ~rsp_full_q;
    assign overrun_o   = overrun_q;
    assign frame_err_o = frame_err_q;

endmodule
